// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the control FSM that drives it.
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } state_t;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the magnitude datapath: shift-add for multiply,
// trial-subtract/restore for divide, over a {hi, lo} accumulator pair.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] trial;
  logic [WIDTH:0] diff;

  // Multiply: add multiplicand when the current multiplier bit is set, then shift right.
  // Divide: shift in the next dividend bit, keep the difference only if it did not borrow.
  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    trial  = {acc_hi, acc_lo[WIDTH-1]};
    diff   = trial - {1'b0, opnd};
    nxt_hi = sum[WIDTH:1];
    nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    if (is_div) begin
      if (!diff[WIDTH]) begin
        nxt_hi = diff[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = trial[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed multiply/divide unit with HI/LO result registers.
// Operates on magnitudes for WIDTH iterations, then applies signs in a FIX cycle.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH,
  parameter int CNT_W = 5
) (
  input  logic             clock,
  input  logic             Reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   nxt_hi;
  logic [WIDTH-1:0]   nxt_lo;
  logic               accept;
  logic               div_by_zero;
  logic               op_div;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   hi_fix;
  logic [WIDTH-1:0]   lo_fix;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] x);
    return x[WIDTH-1] ? WIDTH'(-x) : WIDTH'(x);
  endfunction

  function automatic logic [WIDTH-1:0] cond_neg(input logic neg, input logic [WIDTH-1:0] x);
    return neg ? WIDTH'(-x) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic neg, input logic [2*WIDTH-1:0] x);
    return neg ? (2*WIDTH)'(-x) : x;
  endfunction

  assign op_div      = (op == OP_DIV);
  assign accept      = (state == ST_IDLE) && start && !op[1];
  assign div_by_zero = accept && op_div && (b_in == '0);
  assign a_mag       = magnitude(a_in);
  assign b_mag       = magnitude(b_in);

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div (is_div),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .opnd   (opnd),
    .nxt_hi (nxt_hi),
    .nxt_lo (nxt_lo)
  );

  // Sign correction applied during FIX: product negated as a whole, quotient truncates
  // toward zero, remainder follows the dividend.
  always_comb begin
    prod_fix = cond_neg2(neg_q, {acc_hi, acc_lo});
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      hi_fix = cond_neg(neg_r, acc_hi);
      lo_fix = cond_neg(neg_q, acc_lo);
    end
  end

  // Control FSM with registered busy/done/div_zero.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done     <= 1'b0;
          div_zero <= 1'b0;
          if (accept) begin
            busy <= 1'b1;
            if (div_by_zero) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= ST_RUN;
              cnt   <= CNT_W'(WIDTH - 1);
            end
          end
        end
        ST_RUN: begin
          if (cnt == '0) state <= ST_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        ST_FIX: begin
          state <= ST_DONE;
          done  <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          busy     <= 1'b0;
          done     <= 1'b0;
          div_zero <= 1'b0;
        end
      endcase
    end
  end

  // Operand capture, iteration accumulator, and HI/LO load at the end of FIX.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      if (accept) begin
        is_div <= op_div;
        neg_q  <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
        neg_r  <= a_in[WIDTH-1];
        acc_hi <= '0;
        acc_lo <= op_div ? a_mag : b_mag;
        opnd   <= op_div ? b_mag : a_mag;
      end else if (state == ST_RUN) begin
        acc_hi <= nxt_hi;
        acc_lo <= nxt_lo;
      end else if (state == ST_FIX) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, busy window, signed results,
// divide-by-zero, ignored starts, and asynchronous abort.
module tb_mult_div_unit;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         Reset_n = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a_in = '0;
  logic [W-1:0] b_in = '0;
  logic         busy;
  logic         done;
  logic         div_zero;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int checks = 0;
  int errors = 0;

  int dcyc, dcnt, dzcnt, bbad;

  mult_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clock    (clock),
    .Reset_n  (Reset_n),
    .start    (start),
    .op       (op),
    .a_in     (a_in),
    .b_in     (b_in),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one start in cycle T and observe cycles T+1..T+ncyc at the falling edge.
  // An extra start can be injected in cycle T+inj_cyc.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int ncyc, input int busy_last, input int inj_cyc,
                        input logic [1:0] inj_op,
                        output int done_cyc, output int done_cnt, output int dz_cnt,
                        output int busy_bad);
    done_cyc = -1; done_cnt = 0; dz_cnt = 0; busy_bad = 0;
    @(negedge clock);
    start = 1'b1; op = o; a_in = a; b_in = b;
    for (int n = 1; n <= ncyc; n++) begin
      @(negedge clock);
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (div_zero === 1'b1) dz_cnt++;
      if (busy !== (n <= busy_last)) busy_bad++;
      if (n == inj_cyc) begin
        start = 1'b1; op = inj_op; a_in = 32'd100; b_in = 32'd1;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000", {busy, done, div_zero});
    end
    checks++;
    if (hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL reset_hilo: got %h_%h want 0_0", hi, lo);
    end
    Reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mult_basic();
    run_op(OP_MULT, 32'd7, 32'hFFFFFFFD, 36, 34, 0, 2'b00, dcyc, dcnt, dzcnt, bbad);
    checks++;
    if (dcyc !== 34 || dcnt !== 1) begin
      errors++; $display("FAIL mult_latency: done at %0d count %0d want 34 count 1", dcyc, dcnt);
    end
    checks++;
    if (bbad !== 0) begin
      errors++; $display("FAIL mult_busy: %0d wrong busy cycles want 0", bbad);
    end
    checks++;
    if (dzcnt !== 0) begin
      errors++; $display("FAIL mult_divzero: %0d pulses want 0", dzcnt);
    end
    checks++;
    if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL mult_neg: got %h_%h want ffffffff_ffffffeb", hi, lo);
    end
  endtask

  task automatic test_mult_min();
    run_op(OP_MULT, 32'h80000000, 32'h80000000, 36, 34, 0, 2'b00, dcyc, dcnt, dzcnt, bbad);
    checks++;
    if (hi !== 32'h40000000 || lo !== 32'h00000000 || dcyc !== 34) begin
      errors++; $display("FAIL mult_min: got %h_%h at %0d want 40000000_00000000 at 34", hi, lo, dcyc);
    end
  endtask

  task automatic test_div();
    run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 36, 34, 0, 2'b00, dcyc, dcnt, dzcnt, bbad);
    checks++;
    if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
      errors++; $display("FAIL div_neg: got hi %h lo %h want ffffffff fffffffd", hi, lo);
    end
    checks++;
    if (dcyc !== 34 || dzcnt !== 0 || bbad !== 0) begin
      errors++; $display("FAIL div_timing: done %0d dz %0d busybad %0d want 34 0 0", dcyc, dzcnt, bbad);
    end
    run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 36, 34, 0, 2'b00, dcyc, dcnt, dzcnt, bbad);
    checks++;
    if (lo !== 32'h80000000 || hi !== 32'h0) begin
      errors++; $display("FAIL div_overflow: got hi %h lo %h want 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_div_zero();
    run_op(OP_DIV, 32'h2211, 32'h100, 36, 34, 0, 2'b00, dcyc, dcnt, dzcnt, bbad);
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errors++; $display("FAIL div_preload: got hi %h lo %h want 11 22", hi, lo);
    end
    run_op(OP_DIV, 32'd5, 32'd0, 4, 1, 0, 2'b00, dcyc, dcnt, dzcnt, bbad);
    checks++;
    if (dcyc !== 1 || dcnt !== 1 || dzcnt !== 1) begin
      errors++; $display("FAIL divzero_pulse: done %0d cnt %0d dz %0d want 1 1 1", dcyc, dcnt, dzcnt);
    end
    checks++;
    if (bbad !== 0) begin
      errors++; $display("FAIL divzero_busy: %0d wrong busy cycles want 0", bbad);
    end
    checks++;
    if (hi !== 32'h11 || lo !== 32'h22) begin
      errors++; $display("FAIL divzero_hold: got hi %h lo %h want 11 22", hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    run_op(OP_MULT, 32'h00010001, 32'h00030000, 40, 34, 10, OP_DIV, dcyc, dcnt, dzcnt, bbad);
    checks++;
    if (dcyc !== 34 || dcnt !== 1 || bbad !== 0) begin
      errors++; $display("FAIL ignore_start: done %0d cnt %0d busybad %0d want 34 1 0", dcyc, dcnt, bbad);
    end
    checks++;
    if (hi !== 32'h3 || lo !== 32'h00030000) begin
      errors++; $display("FAIL ignore_result: got %h_%h want 00000003_00030000", hi, lo);
    end
  endtask

  task automatic test_reserved_op();
    run_op(2'b10, 32'd9, 32'd9, 6, 0, 0, 2'b00, dcyc, dcnt, dzcnt, bbad);
    checks++;
    if (dcnt !== 0 || bbad !== 0) begin
      errors++; $display("FAIL reserved_op: done %0d busybad %0d want 0 0", dcnt, bbad);
    end
    checks++;
    if (hi !== 32'h3 || lo !== 32'h00030000) begin
      errors++; $display("FAIL reserved_hold: got %h_%h want 00000003_00030000", hi, lo);
    end
  endtask

  task automatic test_reset_abort();
    int seen;
    seen = 0;
    run_op(OP_MULT, 32'h1234, 32'd5, 14, 34, 0, 2'b00, dcyc, dcnt, dzcnt, bbad);
    @(negedge clock);
    Reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done} !== 2'b00 || hi !== 32'h0 || lo !== 32'h0) begin
      errors++; $display("FAIL abort_clear: busy %b done %b hi %h lo %h want 0 0 0 0", busy, done, hi, lo);
    end
    repeat (3) @(negedge clock);
    Reset_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clock);
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++; $display("FAIL abort_nodone: %0d active cycles want 0", seen);
    end
    run_op(OP_MULT, 32'd3, 32'd4, 36, 34, 0, 2'b00, dcyc, dcnt, dzcnt, bbad);
    checks++;
    if (lo !== 32'd12 || hi !== 32'd0 || dcyc !== 34) begin
      errors++; $display("FAIL post_reset_mult: got %h_%h at %0d want 0_c at 34", hi, lo, dcyc);
    end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_mult_min();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reserved_op();
    test_reset_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
